// File: rtl/sdram_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_port_arbiter_if                                                      |
// | Requester-side and SDRAM-side signals of the three-port SDRAM arbiter.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface sdram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 16
);
  logic [2:0]              req;
  logic [2:0]              we;
  logic [3*ADDR_WIDTH-1:0] addr;
  logic [3*DATA_WIDTH-1:0] wdata;
  logic [5:0]              be;
  logic [2:0]              ack;
  logic [2:0]              rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    busy;

  logic [ADDR_WIDTH-1:0]   sdram_address;
  logic                    sdram_read;
  logic                    sdram_write;
  logic [DATA_WIDTH-1:0]   sdram_writedata;
  logic [1:0]              sdram_byteenable;
  logic                    sdram_waitrequest;
  logic                    sdram_readdatavalid;
  logic [DATA_WIDTH-1:0]   sdram_readdata;

  // The arbiter itself
  modport slave (
    input  req, we, addr, wdata, be,
    input  sdram_waitrequest, sdram_readdatavalid, sdram_readdata,
    output ack, rvalid, rdata, busy,
    output sdram_address, sdram_read, sdram_write, sdram_writedata, sdram_byteenable
  );

  // Everything around it: the requesters and the SDRAM controller
  modport master (
    output req, we, addr, wdata, be,
    output sdram_waitrequest, sdram_readdatavalid, sdram_readdata,
    input  ack, rvalid, rdata, busy,
    input  sdram_address, sdram_read, sdram_write, sdram_writedata, sdram_byteenable
  );
endinterface
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sdram_port_arbiter                                                         |
// | Shares one SDRAM controller port between VGA, CPU and aux requesters.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH     = 22,
  parameter int DATA_WIDTH     = 16,
  parameter int VGA_MAX_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  sdram_port_arbiter_if.slave bus
);

  localparam int                    c_streak_w   = $clog2(VGA_MAX_STREAK + 1);
  localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(VGA_MAX_STREAK);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [1:0]              grant_q, grant_d;
  logic                    we_q, we_d;
  logic [c_streak_w-1:0]   streak_q, streak_d;
  logic                    rr_q, rr_d;
  logic [2:0]              ack_q, ack_d;
  logic [2:0]              rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    busy_q, busy_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [1:0]              be_q, be_d;

  logic [2:0]              w_elig;
  logic                    w_win_valid;
  logic [1:0]              w_win;
  logic                    w_sel_we;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_wdata;
  logic [1:0]              w_sel_be;

  // A requester acked last cycle still shows its old req; it must not win again.
  always_comb begin
    w_elig      = bus.req & ~ack_q;
    w_win_valid = 1'b0;
    w_win       = 2'd0;
    if (w_elig[0] && ((streak_q < c_streak_max) || !(w_elig[1] || w_elig[2]))) begin
      w_win_valid = 1'b1;
      w_win       = 2'd0;
    end else if (w_elig[1] && w_elig[2]) begin
      w_win_valid = 1'b1;
      w_win       = rr_q ? 2'd2 : 2'd1;
    end else if (w_elig[1]) begin
      w_win_valid = 1'b1;
      w_win       = 2'd1;
    end else if (w_elig[2]) begin
      w_win_valid = 1'b1;
      w_win       = 2'd2;
    end
  end

  always_comb begin
    case (w_win)
      2'd1: begin
        w_sel_we    = bus.we[1];
        w_sel_addr  = bus.addr[ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = bus.wdata[DATA_WIDTH +: DATA_WIDTH];
        w_sel_be    = bus.be[3:2];
      end
      2'd2: begin
        w_sel_we    = bus.we[2];
        w_sel_addr  = bus.addr[2*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = bus.wdata[2*DATA_WIDTH +: DATA_WIDTH];
        w_sel_be    = bus.be[5:4];
      end
      default: begin
        w_sel_we    = bus.we[0];
        w_sel_addr  = bus.addr[0 +: ADDR_WIDTH];
        w_sel_wdata = bus.wdata[0 +: DATA_WIDTH];
        w_sel_be    = bus.be[1:0];
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    streak_d = streak_q;
    rr_d     = rr_q;
    ack_d    = 3'b000;
    rvalid_d = 3'b000;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;

    case (state_q)
      S_IDLE: begin
        if (w_win_valid) begin
          grant_d = w_win;
          we_d    = w_sel_we;
          addr_d  = w_sel_addr;
          wdata_d = w_sel_wdata;
          be_d    = w_sel_be;
          rd_d    = ~w_sel_we;
          wr_d    = w_sel_we;
          state_d = S_ISSUE;
          if (w_win == 2'd0) begin
            streak_d = (streak_q == c_streak_max) ? streak_q : streak_q + 1'b1;
          end else begin
            streak_d = '0;
            // rr names the CPU/aux side that goes first next time (1 = aux)
            rr_d     = (w_win == 2'd1);
          end
        end
      end
      S_ISSUE: begin
        if (!bus.sdram_waitrequest) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          ack_d   = 3'b001 << grant_q;
          state_d = we_q ? S_IDLE : S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        if (bus.sdram_readdatavalid) begin
          rdata_d  = bus.sdram_readdata;
          rvalid_d = 3'b001 << grant_q;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= 2'd0;
      we_q     <= 1'b0;
      streak_q <= '0;
      rr_q     <= 1'b0;
      ack_q    <= 3'b000;
      rvalid_q <= 3'b000;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= 2'b00;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      streak_q <= streak_d;
      rr_q     <= rr_d;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
    end
  end

  assign bus.ack              = ack_q;
  assign bus.rvalid           = rvalid_q;
  assign bus.rdata            = rdata_q;
  assign bus.busy             = busy_q;
  assign bus.sdram_address    = addr_q;
  assign bus.sdram_read       = rd_q;
  assign bus.sdram_write      = wr_q;
  assign bus.sdram_writedata  = wdata_q;
  assign bus.sdram_byteenable = be_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sdram_port_arbiter                                                      |
// | Vector table, corner-case sequences and a randomized policy model.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_sdram_port_arbiter;

  localparam int AW   = 22;
  localparam int DW   = 16;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sdram_port_arbiter #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .VGA_MAX_STREAK(MAXS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int             idx;
    logic           we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [1:0]     be;
    int             wait_n;
    int             rdv_dly;
    logic [DW-1:0]  rd;
    int             exp_cmd;
    logic [2:0]     exp_ack;
    logic [2:0]     exp_rvalid;
    logic [DW-1:0]  exp_rdata;
  } vec_t;

  vec_t vecs [6];
  int   grants[$];
  int   exp_starve [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int   exp_rr     [6]  = '{1, 2, 1, 2, 1, 2};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs;
    bus.req                 = 3'b000;
    bus.we                  = 3'b000;
    bus.addr                = '0;
    bus.wdata               = '0;
    bus.be                  = '0;
    bus.sdram_waitrequest   = 1'b0;
    bus.sdram_readdatavalid = 1'b0;
    bus.sdram_readdata      = '0;
  endtask

  task automatic set_slot(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [1:0] b);
    bus.we[i]              = w;
    bus.addr[i*AW +: AW]   = a;
    bus.wdata[i*DW +: DW]  = d;
    bus.be[i*2 +: 2]       = b;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},    bus.ack, 0);
    chk({tag, "_rvalid"}, bus.rvalid, 0);
    chk({tag, "_rdata"},  bus.rdata, 0);
    chk({tag, "_busy"},   bus.busy, 0);
    chk({tag, "_addr"},   bus.sdram_address, 0);
    chk({tag, "_read"},   bus.sdram_read, 0);
    chk({tag, "_write"},  bus.sdram_write, 0);
    chk({tag, "_wdata"},  bus.sdram_writedata, 0);
    chk({tag, "_be"},     bus.sdram_byteenable, 0);
  endtask

  task automatic apply_reset;
    quiet_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // One isolated transaction from a single requester, acting as the controller.
  task automatic do_txn(input vec_t v);
    int k;
    bit timeout;
    set_slot(v.idx, v.we, v.addr, v.wdata, v.be);
    bus.req = 3'(1 << v.idx);
    tick();
    chk("cmd_latency", bus.sdram_read | bus.sdram_write, 1);
    k = 0;
    timeout = 1'b0;
    while ((bus.sdram_read || bus.sdram_write) && !timeout) begin
      chk("cmd_read",  bus.sdram_read, !v.we);
      chk("cmd_write", bus.sdram_write, v.we);
      chk("cmd_addr",  bus.sdram_address, v.addr);
      chk("cmd_be",    bus.sdram_byteenable, v.be);
      if (v.we) chk("cmd_wdata", bus.sdram_writedata, v.wdata);
      chk("ack_during_cmd", bus.ack, 0);
      bus.sdram_waitrequest = (k < v.wait_n);
      k++;
      tick();
      if (k > 40) timeout = 1'b1;
    end
    chk("cmd_timeout", timeout, 0);
    chk("cmd_cycles", k, v.exp_cmd);
    chk("ack", bus.ack, v.exp_ack);
    bus.req = 3'b000;
    bus.sdram_waitrequest = 1'b0;
    if (!v.we) begin
      for (int d = 0; d <= v.rdv_dly; d++) begin
        bus.sdram_readdatavalid = (d == v.rdv_dly);
        bus.sdram_readdata      = v.rd;
        tick();
        if (d == 0) chk("ack_pulse", bus.ack, 0);
        if (d < v.rdv_dly) chk("rvalid_early", bus.rvalid, 0);
      end
      bus.sdram_readdatavalid = 1'b0;
    end
    chk("rvalid", bus.rvalid, v.exp_rvalid);
    chk("rdata", bus.rdata, v.exp_rdata);
    chk("busy_done", bus.busy, 0);
    tick();
    chk("ack_clear", bus.ack, 0);
    chk("rvalid_clear", bus.rvalid, 0);
  endtask

  // Requesters hold req continuously; the controller never stalls and always returns data.
  task automatic run_grants(input logic [2:0] rq, input logic [2:0] wem, input int n);
    grants.delete();
    for (int i = 0; i < 3; i++) set_slot(i, wem[i], AW'(22'h100 * (i + 1)), DW'(16'h1000 + i), 2'b11);
    bus.req = rq;
    bus.sdram_waitrequest   = 1'b0;
    bus.sdram_readdatavalid = 1'b1;
    bus.sdram_readdata      = 16'h0F0F;
    for (int c = 0; c < 400 && grants.size() < n; c++) begin
      tick();
      if (bus.ack[0])      grants.push_back(0);
      else if (bus.ack[1]) grants.push_back(1);
      else if (bus.ack[2]) grants.push_back(2);
    end
    bus.req = 3'b000;
    repeat (4) tick();
    bus.sdram_readdatavalid = 1'b0;
    tick();
    chk("grant_count", grants.size(), n);
  endtask

  function automatic int grant_at(input int i);
    return (i < grants.size()) ? grants[i] : -1;
  endfunction

  // Randomized traffic against a transaction-level model of the arbitration policy.
  task automatic run_random(input int ncyc);
    int            vga_run, ca_next, phase, g, w;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata, last_rdd;
    logic [1:0]    m_be;
    logic [2:0]    pend, last_req, last_ack, elig, exp_ack, exp_rv;
    logic          last_wait, last_rdv;
    logic          p_we [3];
    logic [AW-1:0] p_addr [3];
    logic [DW-1:0] p_wdata [3];
    logic [1:0]    p_be [3];
    int            rate [3];
    rate = '{70, 30, 20};
    apply_reset();
    vga_run = 0; ca_next = 1; phase = 0; g = 0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0; m_be = '0; m_rdata = '0;
    pend = '0; last_req = '0; last_ack = '0; last_wait = 1'b0; last_rdv = 1'b0; last_rdd = '0;
    for (int i = 0; i < 3; i++) begin
      p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0; p_be[i] = '0;
    end
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      tick();
      exp_ack = '0;
      exp_rv  = '0;
      if (phase == 0) begin
        elig = last_req & ~last_ack;
        if (elig != 0) begin
          if (elig[0] && (vga_run < MAXS || !(elig[1] || elig[2]))) begin
            w = 0;
            if (vga_run < MAXS) vga_run++;
          end else begin
            w = (elig[1] && elig[2]) ? ca_next : (elig[1] ? 1 : 2);
            ca_next = 3 - w;
            vga_run = 0;
          end
          g = w; m_we = p_we[w]; m_addr = p_addr[w]; m_wdata = p_wdata[w]; m_be = p_be[w];
          phase = 1;
          chk("rnd_cmd_start", bus.sdram_read | bus.sdram_write, 1);
        end else begin
          chk("rnd_no_cmd", bus.sdram_read | bus.sdram_write, 0);
        end
      end else if (phase == 1) begin
        if (!last_wait) begin
          exp_ack = 3'(1 << g);
          phase = m_we ? 0 : 2;
          chk("rnd_cmd_drop", bus.sdram_read | bus.sdram_write, 0);
        end
      end else if (last_rdv) begin
        exp_rv  = 3'(1 << g);
        m_rdata = last_rdd;
        phase   = 0;
      end
      if (phase == 1) begin
        chk("rnd_read",  bus.sdram_read, !m_we);
        chk("rnd_write", bus.sdram_write, m_we);
        chk("rnd_addr",  bus.sdram_address, m_addr);
        chk("rnd_be",    bus.sdram_byteenable, m_be);
        if (m_we) chk("rnd_wdata", bus.sdram_writedata, m_wdata);
      end
      chk("rnd_ack",    bus.ack, exp_ack);
      chk("rnd_rvalid", bus.rvalid, exp_rv);
      chk("rnd_rdata",  bus.rdata, m_rdata);
      chk("rnd_busy",   bus.busy, phase != 0);

      for (int i = 0; i < 3; i++) begin
        if (bus.ack[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 99) < rate[i]) begin
          pend[i]    = 1'b1;
          p_we[i]    = 1'($urandom_range(0, 1));
          p_addr[i]  = AW'($urandom);
          p_wdata[i] = DW'($urandom);
          p_be[i]    = 2'($urandom_range(0, 3));
          set_slot(i, p_we[i], p_addr[i], p_wdata[i], p_be[i]);
        end
      end
      bus.req                 = pend;
      bus.sdram_waitrequest   = ($urandom_range(0, 2) == 0);
      bus.sdram_readdatavalid = ($urandom_range(0, 2) == 0);
      bus.sdram_readdata      = DW'($urandom);
      last_req  = pend;
      last_ack  = bus.ack;
      last_wait = bus.sdram_waitrequest;
      last_rdv  = bus.sdram_readdatavalid;
      last_rdd  = bus.sdram_readdata;
    end
  endtask

  initial begin
    //            idx we addr        wdata    be     wait rdv rd       cmd ack     rvalid  rdata
    vecs[0] = '{1, 1'b1, 22'h001234, 16'hBEEF, 2'b11, 0, 0, 16'h0000, 1, 3'b010, 3'b000, 16'h0000};
    vecs[1] = '{2, 1'b0, 22'h3FFFFF, 16'h0000, 2'b11, 5, 3, 16'hA5C3, 6, 3'b100, 3'b100, 16'hA5C3};
    vecs[2] = '{0, 1'b0, 22'h000000, 16'h0000, 2'b01, 0, 0, 16'h1357, 1, 3'b001, 3'b001, 16'h1357};
    vecs[3] = '{0, 1'b1, 22'h2AAAAA, 16'h5555, 2'b10, 2, 0, 16'h0000, 3, 3'b001, 3'b000, 16'h1357};
    vecs[4] = '{1, 1'b0, 22'h155555, 16'h0000, 2'b11, 1, 2, 16'hFFFF, 2, 3'b010, 3'b010, 16'hFFFF};
    vecs[5] = '{2, 1'b1, 22'h000001, 16'hC0DE, 2'b00, 0, 0, 16'h0000, 1, 3'b100, 3'b000, 16'hFFFF};

    quiet_inputs();
    reset = 1'b1;
    tick();
    tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // Stray readdatavalid while idle
    bus.sdram_readdatavalid = 1'b1;
    bus.sdram_readdata      = 16'h1111;
    tick();
    chk("stray_rvalid", bus.rvalid, 0);
    tick();
    chk("stray_rvalid2", bus.rvalid, 0);
    chk("stray_rdata", bus.rdata, 16'hFFFF);
    chk("stray_busy", bus.busy, 0);
    bus.sdram_readdatavalid = 1'b0;

    apply_reset();
    run_grants(3'b011, 3'b000, 10);
    for (int i = 0; i < 10; i++) chk($sformatf("starve_grant%0d", i), grant_at(i), exp_starve[i]);

    apply_reset();
    run_grants(3'b001, 3'b000, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("vga_only_grant%0d", i), grant_at(i), 0);

    apply_reset();
    run_grants(3'b110, 3'b110, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_grant%0d", i), grant_at(i), exp_rr[i]);

    // Reset while a read is waiting for data
    apply_reset();
    set_slot(2, 1'b0, 22'h0ABCDE, 16'h0000, 2'b11);
    bus.req = 3'b100;
    for (int c = 0; c < 10 && !bus.ack[2]; c++) tick();
    chk("midrd_ack", bus.ack, 3'b100);
    bus.req = 3'b000;
    reset = 1'b1;
    #1;
    chk_all_zero("midrd_async");
    bus.sdram_readdatavalid = 1'b1;
    bus.sdram_readdata      = 16'hDEAD;
    tick();
    reset = 1'b0;
    tick();
    chk_all_zero("midrd_after");
    bus.sdram_readdatavalid = 1'b0;
    tick();
    do_txn(vecs[0]);

    run_random(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
